multicycle_stage_sequencer: RTL and testbench

Parametrised successor to the fixed 5-stage STAGE_CONTROLLER. It sequences a multi-cycle CPU through NUM_STAGES stages and emits one-cycle write-enable pulses for the pipeline registers, RAM, register file and PC. Each stage has a configurable wait-cycle count, and the MEM stage has a memory-ready handshake. The block also adds halt/single-step debug control and cycle/retired-instruction counters. It sits beside the datapath at CPU top level and drives all *_wren and stage_reset_n nets.

---
 rtl/multicycle_stage_sequencer.sv | 173 +++++++++++++++++
 tb/tb_multicycle_stage_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_stage_sequencer.sv
// Stage sequencer for a multi-cycle CPU: walks NUM_STAGES stages with per-stage wait
// counts, a MEM ready handshake, halt/single-step debug control and activity counters.
module multicycle_stage_sequencer #(
    parameter int NUM_STAGES    = 5,
    parameter int IF_INDEX      = 0,
    parameter int MEM_INDEX     = 3,
    parameter int WB_INDEX      = 4,
    parameter int IF_WAIT       = 1,
    parameter int MEM_WAIT      = 1,
    parameter int INIT_CYCLES   = 2,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          mem_ready,
    input  logic                          halt_req,
    input  logic                          step_req,
    output logic [NUM_STAGES-1:0]         stage_wren,
    output logic                          ram_wren,
    output logic                          reg_wren,
    output logic                          pc_wren,
    output logic                          stage_reset_n,
    output logic [$clog2(NUM_STAGES)-1:0] current_stage,
    output logic                          halted,
    output logic [COUNTER_WIDTH-1:0]      cycle_count,
    output logic [COUNTER_WIDTH-1:0]      retired_count
);

    localparam int SW       = $clog2(NUM_STAGES);
    localparam int MAX_WAIT = (IF_WAIT > MEM_WAIT) ? IF_WAIT : MEM_WAIT;
    localparam int WW       = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int IW       = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;

    localparam logic [SW-1:0] IF_IDX     = SW'(IF_INDEX);
    localparam logic [SW-1:0] MEM_IDX    = SW'(MEM_INDEX);
    localparam logic [SW-1:0] LAST_IDX   = SW'(NUM_STAGES - 1);
    localparam logic [WW-1:0] IF_WAIT_W  = WW'(IF_WAIT);
    localparam logic [WW-1:0] MEM_WAIT_W = WW'(MEM_WAIT);
    localparam logic [IW-1:0] INIT_W     = IW'(INIT_CYCLES);
    localparam logic [IW-1:0] ONE_W      = IW'(1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t                   state_reg, state_next;
    logic [SW-1:0]            stage_reg, stage_next;
    logic [WW-1:0]            wait_reg, wait_next;
    logic [IW-1:0]            init_reg, init_next;
    logic                     step_reg, step_next;
    logic [COUNTER_WIDTH-1:0] cycle_reg, cycle_next;
    logic [COUNTER_WIDTH-1:0] retired_reg, retired_next;

    logic commit;
    logic last_commit;

    // Wait cycles loaded when a stage is entered.
    function automatic logic [WW-1:0] entry_wait(input logic [SW-1:0] idx);
        if (idx == IF_IDX) begin
            return IF_WAIT_W;
        end else if (idx == MEM_IDX) begin
            return MEM_WAIT_W;
        end else begin
            return '0;
        end
    endfunction

    // mem_ready feeds the commit strobe combinationally so MEM commits in the ready cycle.
    assign commit      = (state_reg == ST_RUN) && (wait_reg == '0) &&
                         ((stage_reg != MEM_IDX) || mem_ready);
    assign last_commit = commit && (stage_reg == LAST_IDX);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_wren
            assign stage_wren[gi] = commit && (stage_reg == SW'(gi));
        end
    endgenerate

    assign ram_wren      = stage_wren[MEM_INDEX];
    assign reg_wren      = stage_wren[WB_INDEX];
    assign pc_wren       = stage_wren[NUM_STAGES-1];
    assign stage_reset_n = (state_reg != ST_INIT);
    assign halted        = (state_reg == ST_HALTED);
    assign current_stage = stage_reg;
    assign cycle_count   = cycle_reg;
    assign retired_count = retired_reg;

    always_comb begin
        state_next   = state_reg;
        stage_next   = stage_reg;
        wait_next    = wait_reg;
        init_next    = init_reg;
        step_next    = step_reg;
        cycle_next   = cycle_reg;
        retired_next = retired_reg;

        case (state_reg)
            ST_INIT: begin
                if (init_reg <= ONE_W) begin
                    state_next = ST_RUN;
                    stage_next = '0;
                    wait_next  = entry_wait('0);
                end else begin
                    init_next = init_reg - ONE_W;
                end
            end
            ST_RUN: begin
                cycle_next = cycle_reg + 1'b1;
                if (wait_reg != '0) begin
                    wait_next = wait_reg - 1'b1;
                end else if (last_commit) begin
                    retired_next = retired_reg + 1'b1;
                    stage_next   = '0;
                    // A stepped instruction always returns to HALTED.
                    if (step_reg || halt_req) begin
                        state_next = ST_HALTED;
                        wait_next  = '0;
                        step_next  = 1'b0;
                    end else begin
                        wait_next = entry_wait('0);
                    end
                end else if (commit) begin
                    stage_next = stage_reg + 1'b1;
                    wait_next  = entry_wait(stage_reg + 1'b1);
                end
            end
            ST_HALTED: begin
                if (step_req) begin
                    state_next = ST_RUN;
                    stage_next = '0;
                    wait_next  = entry_wait('0);
                    step_next  = 1'b1;
                end else if (!halt_req) begin
                    state_next = ST_RUN;
                    stage_next = '0;
                    wait_next  = entry_wait('0);
                    step_next  = 1'b0;
                end
            end
            default: begin
                state_next = ST_INIT;
                stage_next = '0;
                wait_next  = '0;
                init_next  = INIT_W;
                step_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_INIT;
            stage_reg   <= '0;
            wait_reg    <= '0;
            init_reg    <= INIT_W;
            step_reg    <= 1'b0;
            cycle_reg   <= '0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            stage_reg   <= stage_next;
            wait_reg    <= wait_next;
            init_reg    <= init_next;
            step_reg    <= step_next;
            cycle_reg   <= cycle_next;
            retired_reg <= retired_next;
        end
    end

endmodule

// File: tb/tb_multicycle_stage_sequencer.sv
// Bench for multicycle_stage_sequencer: vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model; a 4-stage instance is also checked.
module tb_multicycle_stage_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_ready = 1'b1;
    logic        halt_req = 1'b0;
    logic        step_req = 1'b0;
    logic [4:0]  sw1;
    logic        ram1, reg1, pc1, srn1, halted1;
    logic [2:0]  cs1;
    logic [31:0] cc1, rc1;

    logic        mem_ready2 = 1'b1;
    logic        halt_req2 = 1'b0;
    logic        step_req2 = 1'b0;
    logic [3:0]  sw2;
    logic        ram2, reg2, pc2, srn2, halted2;
    logic [1:0]  cs2;
    logic [31:0] cc2, rc2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multicycle_stage_sequencer dut (
        .clk(clk), .reset_n(reset_n), .mem_ready(mem_ready), .halt_req(halt_req),
        .step_req(step_req), .stage_wren(sw1), .ram_wren(ram1), .reg_wren(reg1),
        .pc_wren(pc1), .stage_reset_n(srn1), .current_stage(cs1), .halted(halted1),
        .cycle_count(cc1), .retired_count(rc1)
    );

    multicycle_stage_sequencer #(
        .NUM_STAGES(4), .MEM_INDEX(2), .WB_INDEX(3), .MEM_WAIT(0), .IF_WAIT(0)
    ) dut4 (
        .clk(clk), .reset_n(reset_n), .mem_ready(mem_ready2), .halt_req(halt_req2),
        .step_req(step_req2), .stage_wren(sw2), .ram_wren(ram2), .reg_wren(reg2),
        .pc_wren(pc2), .stage_reset_n(srn2), .current_stage(cs2), .halted(halted2),
        .cycle_count(cc2), .retired_count(rc2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_taps(input logic [4:0] w);
        check("ram_wren", ram1, w[3]);
        check("reg_wren", reg1, w[4]);
        check("pc_wren", pc1, w[4]);
    endtask

    // Reset is asserted at a falling edge, held, and released at a falling edge.
    task automatic reset_seq();
        @(negedge clk);
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        halt_req  = 1'b0;
        step_req  = 1'b0;
        #1;
        check("rst_srn", srn1, 0);
        check("rst_wren", sw1, 0);
        check("rst_stage", cs1, 0);
        check("rst_halted", halted1, 0);
        check("rst_cycles", cc1, 0);
        check("rst_retired", rc1, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Reference model: an instruction is a queue of per-cycle slots (stage*2 + is_commit).
    int          m_init;
    bit          m_halted, m_step;
    int          mq[$];
    logic [31:0] m_cc, m_rc;

    function automatic void m_fill();
        for (int s = 0; s < 5; s++) begin
            int w;
            w = (s == 0) ? 1 : ((s == 3) ? 1 : 0);
            for (int k = 0; k < w; k++) mq.push_back(s * 2);
            mq.push_back(s * 2 + 1);
        end
    endfunction

    function automatic void m_reset();
        m_init = 2;
        m_halted = 0;
        m_step = 0;
        mq.delete();
        m_cc = 0;
        m_rc = 0;
    endfunction

    function automatic void m_expect(input logic mr, output logic [4:0] w, output logic [2:0] st,
                                     output logic h, output logic srn);
        w = '0; st = '0; h = 1'b0; srn = 1'b1;
        if (m_init > 0) begin
            srn = 1'b0;
        end else if (m_halted) begin
            h = 1'b1;
        end else begin
            int e, s;
            e = mq[0];
            s = e / 2;
            st = 3'(s);
            if ((e % 2 == 1) && (s != 3 || mr)) w = 5'd1 << s;
        end
    endfunction

    function automatic void m_advance(input logic mr, input logic hr, input logic sr);
        if (m_init > 0) begin
            m_init--;
            if (m_init == 0) m_fill();
        end else if (m_halted) begin
            if (sr) begin
                m_halted = 0; m_step = 1; m_fill();
            end else if (!hr) begin
                m_halted = 0; m_step = 0; m_fill();
            end
        end else begin
            int e, s;
            e = mq[0];
            s = e / 2;
            m_cc++;
            if (e % 2 == 0) begin
                void'(mq.pop_front());
            end else if (s != 3 || mr) begin
                void'(mq.pop_front());
                if (s == 4) begin
                    m_rc++;
                    if (m_step || hr) begin
                        m_halted = 1; m_step = 0;
                    end else begin
                        m_fill();
                    end
                end
            end
        end
    endfunction

    typedef struct {
        logic       mr, hr, sr;
        logic       srn;
        logic [4:0] wren;
        logic [2:0] stage;
        logic       halted;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic mr, input logic hr, input logic sr, input logic srn,
                       input logic [4:0] w, input logic [2:0] st, input logic h);
        vec_t v;
        v.mr = mr; v.hr = hr; v.sr = sr; v.srn = srn; v.wren = w; v.stage = st; v.halted = h;
        vq.push_back(v);
    endtask

    initial begin
        int runs, pulses;
        logic [4:0] ew;
        logic [2:0] est;
        logic eh, esrn;

        // Rows start at the cycle right after reset release.
        add(1, 0, 0, 0, 5'h00, 0, 0);
        add(1, 0, 0, 0, 5'h00, 0, 0);
        add(1, 0, 0, 1, 5'h00, 0, 0);
        add(1, 0, 0, 1, 5'h01, 0, 0);
        add(1, 0, 0, 1, 5'h02, 1, 0);
        add(0, 0, 0, 1, 5'h04, 2, 0);
        add(0, 0, 0, 1, 5'h00, 3, 0);
        add(0, 0, 0, 1, 5'h00, 3, 0);
        add(1, 0, 0, 1, 5'h08, 3, 0);
        add(1, 1, 0, 1, 5'h10, 4, 0);
        add(1, 1, 0, 1, 5'h00, 0, 1);
        add(1, 1, 1, 1, 5'h00, 0, 1);
        add(1, 1, 0, 1, 5'h00, 0, 0);
        add(1, 1, 0, 1, 5'h01, 0, 0);
        add(0, 1, 0, 1, 5'h02, 1, 0);
        add(0, 0, 0, 1, 5'h04, 2, 0);
        add(1, 0, 0, 1, 5'h00, 3, 0);
        add(1, 0, 0, 1, 5'h08, 3, 0);
        add(1, 0, 0, 1, 5'h10, 4, 0);
        add(1, 0, 0, 1, 5'h00, 0, 1);
        add(1, 0, 0, 1, 5'h00, 0, 0);
        add(1, 0, 0, 1, 5'h01, 0, 0);

        reset_seq();
        foreach (vq[i]) begin
            mem_ready = vq[i].mr;
            halt_req  = vq[i].hr;
            step_req  = vq[i].sr;
            #1;
            check("vec_srn", srn1, vq[i].srn);
            check("vec_wren", sw1, vq[i].wren);
            check("vec_stage", cs1, vq[i].stage);
            check("vec_halted", halted1, vq[i].halted);
            check_taps(vq[i].wren);
            $display("vec %0d: wren=%b stage=%0d halted=%b srn=%b", i, sw1, cs1, halted1, srn1);
            @(negedge clk);
        end

        // Free run: 7-cycle pattern on the default instance, 4-cycle walk on the small one.
        reset_seq();
        for (int i = 0; i < 2; i++) begin
            #1;
            check("init_srn", srn1, 0);
            check("init_srn4", srn2, 0);
            @(negedge clk);
        end
        for (int n = 1; n <= 70; n++) begin
            logic [4:0] w;
            #1;
            case (n % 7)
                2: w = 5'h01;
                3: w = 5'h02;
                4: w = 5'h04;
                6: w = 5'h08;
                0: w = 5'h10;
                default: w = 5'h00;
            endcase
            check("run_wren", sw1, w);
            check_taps(w);
            if (n <= 40) begin
                check("run4_wren", sw2, 4'b0001 << ((n - 1) % 4));
                check("run4_stage", cs2, (n - 1) % 4);
                check("run4_ram", ram2, ((n - 1) % 4) == 2);
                check("run4_reg", reg2, ((n - 1) % 4) == 3);
                check("run4_pc", pc2, ((n - 1) % 4) == 3);
                check("run4_halted", halted2, 0);
            end
            if (n == 41) begin
                check("run4_cycles", cc2, 40);
                check("run4_retired", rc2, 10);
            end
            @(negedge clk);
        end
        #1;
        check("run_cycles", cc1, 70);
        check("run_retired", rc1, 10);
        $display("free run: cycles=%0d retired=%0d", cc1, rc1);

        // Halt raised during EX: the instruction still completes, then the core stops.
        repeat (3) @(negedge clk);
        halt_req = 1'b1;
        #1 check("halt_ex_wren", sw1, 5'h04);
        repeat (2) @(negedge clk);
        #1 check("halt_mem_wren", sw1, 5'h08);
        @(negedge clk);
        #1 check("halt_wb_wren", sw1, 5'h10);
        @(negedge clk);
        #1;
        check("halt_enter", halted1, 1);
        check("halt_cycles", cc1, 77);
        check("halt_retired", rc1, 11);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            check("halt_wren", sw1, 0);
            check("halt_stage", cs1, 0);
            check("halt_held", halted1, 1);
        end
        check("halt_frozen_cycles", cc1, 77);
        check("halt_frozen_retired", rc1, 11);
        $display("halt: cycles=%0d retired=%0d", cc1, rc1);

        // One-cycle step while halt stays requested.
        @(negedge clk);
        step_req = 1'b1;
        #1 check("step_req_cycle", halted1, 1);
        @(negedge clk);
        step_req = 1'b0;
        runs = 0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (halted1) break;
            runs++;
            if (sw1 != 0) pulses++;
            @(negedge clk);
        end
        check("step_run_cycles", runs, 7);
        check("step_pulses", pulses, 5);
        check("step_retired", rc1, 12);
        check("step_rehalt", halted1, 1);
        $display("step: run_cycles=%0d pulses=%0d retired=%0d", runs, pulses, rc1);

        halt_req = 1'b0;
        @(negedge clk);
        #1 check("resume", halted1, 0);
        repeat (14) @(negedge clk);
        #1 check("resume_retired", rc1, 14);

        // Asynchronous reset in the middle of a MEM stall.
        mem_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (cs1 == 3) break;
        end
        check("stall_reach_mem", cs1, 3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("stall_wren", sw1, 0);
            check("stall_stage", cs1, 3);
        end
        reset_n = 1'b0;
        #1;
        check("async_srn", srn1, 0);
        check("async_wren", sw1, 0);
        check("async_stage", cs1, 0);
        check("async_cycles", cc1, 0);
        check("async_retired", rc1, 0);
        check("async_retired4", rc2, 0);
        @(negedge clk);
        mem_ready = 1'b1;
        reset_n = 1'b1;
        #1 check("reinit_srn0", srn1, 0);
        @(negedge clk);
        #1 check("reinit_srn1", srn1, 0);
        @(negedge clk);
        #1;
        check("reinit_run_srn", srn1, 1);
        check("reinit_stage", cs1, 0);
        check("reinit_wait", sw1, 0);
        @(negedge clk);
        #1 check("reinit_if_commit", sw1, 5'h01);
        $display("mid-stall reset: restart at IF ok=%0d", sw1 == 5'h01);

        // Randomized run against the reference model.
        reset_seq();
        m_reset();
        for (int c = 0; c < 1500; c++) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) halt_req = ~halt_req;
            step_req = ($urandom_range(0, 7) == 0);
            #1;
            m_expect(mem_ready, ew, est, eh, esrn);
            check("rnd_wren", sw1, ew);
            check("rnd_stage", cs1, est);
            check("rnd_halted", halted1, eh);
            check("rnd_srn", srn1, esrn);
            check("rnd_cycles", cc1, m_cc);
            check("rnd_retired", rc1, m_rc);
            check_taps(ew);
            m_advance(mem_ready, halt_req, step_req);
            @(negedge clk);
        end
        $display("random: cycles=%0d retired=%0d", m_cc, m_rc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
